// File: rtl/demux_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux_scheduler                                               |
// | Purpose  : One-deep round-robin demux; a stalled lane is skipped after   |
// |            TIMEOUT cycles. Define DEMUX_SCHED_COUNT_EN to add the        |
// |            per-lane saturating delivery counters (dcount port).          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module demux_scheduler #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy
`ifdef DEMUX_SCHED_COUNT_EN
  ,
  output logic [4*CNT_W-1:0] dcount
`endif
);

  localparam logic [3:0] c_WAIT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_sel;
  logic [1:0]        w_sel_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        w_ptr_nxt;
  logic [3:0]        r_wait;
  logic [3:0]        w_wait_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_xfer;

  if (TIMEOUT < 1 || TIMEOUT > 15 || CNT_W < 1) begin : g_param_chk
    $error("demux_scheduler: TIMEOUT must be 1..15 and CNT_W at least 1");
  end

  // Only the targeted lane's ready bit matters.
  assign w_xfer   = (r_state == S_HOLD) && out_ready[r_sel];
  assign out_data = r_data;
  assign sel      = r_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_wait  <= 4'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wait  <= w_wait_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_wait_nxt  = r_wait;
    w_data_nxt  = r_data;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 4'b0000;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_data_nxt  = in_data;
          w_sel_nxt   = r_ptr;
          w_wait_nxt  = 4'd0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 4'b0001 << r_sel;
        if (w_xfer) begin
          w_ptr_nxt   = r_sel + 2'd1;
          w_state_nxt = S_IDLE;
        end else if (r_wait == c_WAIT_LAST) begin
          // Give up on this lane but keep the word; 2-bit add wraps 3 -> 0.
          w_sel_nxt  = r_sel + 2'd1;
          w_wait_nxt = 4'd0;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef DEMUX_SCHED_COUNT_EN
  for (genvar i = 0; i < 4; i++) begin : g_lane_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_xfer && (r_sel == 2'(i)) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign dcount[i*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_scheduler.sv
`default_nettype none
// Bench for demux_scheduler: reference model compared every cycle plus directed literal checks.
module tb_demux_scheduler;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready = 4'b0000;
  logic [1:0]        sel;
  logic              busy;
`ifdef DEMUX_SCHED_COUNT_EN
  logic [4*CNT_W-1:0] dcount;
`endif

  demux_scheduler #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel),
    .busy     (busy)
`ifdef DEMUX_SCHED_COUNT_EN
    ,
    .dcount   (dcount)
`endif
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a held word, its target lane, how long it has stalled there, next lane to use.
  bit          m_held;
  logic [7:0]  m_data;
  int          m_sel, m_ptr, m_stall;
  int          m_cnt[4];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_held = 0; m_data = 8'h00; m_sel = 0; m_ptr = 0; m_stall = 0;
      for (int l = 0; l < 4; l++) m_cnt[l] = 0;
    end else if (!m_held) begin
      if (in_valid) begin
        m_held = 1; m_data = in_data; m_sel = m_ptr; m_stall = 0;
      end
    end else if (out_ready[m_sel]) begin
      m_held = 0;
      m_ptr  = (m_sel + 1) % 4;
      if (m_cnt[m_sel] < (1 << CNT_W) - 1) m_cnt[m_sel]++;
    end else begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_sel   = (m_sel + 1) % 4;
        m_stall = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_in_ready", in_ready, !m_held);
      check("model_busy", busy, m_held);
      check("model_out_valid", out_valid, m_held ? (32'd1 << m_sel) : 32'd0);
      check("model_sel", sel, m_sel);
      check("model_out_data", out_data, m_data);
`ifdef DEMUX_SCHED_COUNT_EN
      for (int l = 0; l < 4; l++) check("model_dcount", dcount[l*CNT_W +: CNT_W], m_cnt[l]);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_bound", busy, 1'b0);
  endtask

  logic [3:0] exp_rr [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] exp_rot[5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] pats   [8]  = '{4'b1111, 4'b0000, 4'b0101, 4'b1010, 4'b0001, 4'b1000, 4'b0110, 4'b0011};

  initial begin
    tick();
    tick();
    reset  = 1'b0;
    cmp_en = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_sel", sel, 2'd0);
    check("rst_out_data", out_data, 8'h00);

    // First word to lane 0, second to lane 1.
    out_ready = 4'b1111;
    send(8'h11);
    check("w1_out_valid", out_valid, 4'b0001);
    check("w1_out_data", out_data, 8'h11);
    tick();
    check("w1_done_busy", busy, 1'b0);
    check("w1_done_in_ready", in_ready, 1'b1);
    send(8'h22);
    check("w2_out_valid", out_valid, 4'b0010);
    check("w2_out_data", out_data, 8'h22);
    tick();

    // Round robin with wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'hA0 + 8'(i));
      check("rr_out_valid", out_valid, exp_rr[i]);
      check("rr_out_data", out_data, 8'hA0 + 8'(i));
      tick();
    end

    // Lane 2 stalls for TIMEOUT cycles, word moves to lane 3.
    do_reset();
    out_ready = 4'b1111;
    send(8'h01); tick();
    send(8'h02); tick();
    out_ready = 4'b1011;
    send(8'h77);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("stall_lane2", out_valid, 4'b0100);
      tick();
    end
    check("skip_to_lane3", out_valid, 4'b1000);
    check("skip_keeps_data", out_data, 8'h77);
    tick();
    check("lane3_done_busy", busy, 1'b0);
    send(8'h78);
    check("ptr_wrapped_to_0", out_valid, 4'b0001);
    tick();

    // Nothing ready: lane rotates every TIMEOUT cycles, word held.
    do_reset();
    out_ready = 4'b0000;
    send(8'h3C);
    for (int c = 0; c < 20; c++) begin
      check("rot_sel", sel, exp_rot[c/4]);
      check("rot_busy", busy, 1'b1);
      check("rot_data", out_data, 8'h3C);
      tick();
    end
    check("rot_sel_after", sel, 2'd1);
    out_ready = 4'b1111;
    tick();
    check("rot_release", busy, 1'b0);

    // Asynchronous reset in the middle of HOLD.
    out_ready = 4'b0000;
    send(8'h5A);
    tick(); tick();
    check("pre_areset_data", out_data, 8'h5A);
    check("pre_areset_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("areset_out_data", out_data, 8'h00);
    check("areset_out_valid", out_valid, 4'b0000);
    check("areset_busy", busy, 1'b0);
    check("areset_in_ready", in_ready, 1'b1);
    check("areset_sel", sel, 2'd0);
    tick();
    reset = 1'b0;
    out_ready = 4'b1111;
    send(8'h66);
    check("post_areset_lane0", out_valid, 4'b0001);
    tick();

    // Streaming with mixed ready patterns; the model checks every cycle.
    for (int i = 0; i < 24; i++) begin
      out_ready = pats[i % 8];
      in_valid  = 1'b1;
      in_data   = 8'(i * 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    wait_idle(64);

`ifdef DEMUX_SCHED_COUNT_EN
    do_reset();
    out_ready = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      send(8'hC0 + 8'(i));
      wait_idle(40);
    end
    check("dcount_lane0", dcount[0*CNT_W +: CNT_W], 2'd0);
    check("dcount_lane1_sat", dcount[1*CNT_W +: CNT_W], 2'd3);
    check("dcount_lane2", dcount[2*CNT_W +: CNT_W], 2'd0);
    check("dcount_lane3", dcount[3*CNT_W +: CNT_W], 2'd0);
`endif

    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter: DATA_W, default 8, width of the steered data word.
REQ-002 Parameter: TIMEOUT, default 4, number of stalled cycles before the target output is skipped (legal range 1..15).
REQ-003 Parameter: CNT_W, default 8, width of each per-output delivery counter (used only under REQ-025).
REQ-004 Port: clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-006 Port: in_valid, input, 1, the upstream word is present.
REQ-007 Port: in_data, input, DATA_W, the upstream word.
REQ-008 Port: in_ready, output, 1, the scheduler can accept a word this cycle.
REQ-009 Port: out_valid, output, 4, one-hot valid, one bit per output lane.
REQ-010 Port: out_data, output, DATA_W, the held word, shared by all lanes.
REQ-011 Port: out_ready, input, 4, per-lane acceptance from downstream.
REQ-012 Port: sel, output, 2, the index of the lane currently targeted.
REQ-013 Port: busy, output, 1, high while a word is held.

Function
REQ-014 The module SHALL use a two-state FSM: IDLE (no word held) and HOLD (one word held).
REQ-015 In IDLE, in_ready SHALL be 1, out_valid SHALL be 0 and busy SHALL be 0.
REQ-016 In IDLE, in_valid=1 at a clock edge SHALL capture in_data into out_data, load sel from the round-robin pointer ptr, clear the wait counter and enter HOLD.
REQ-017 In HOLD, in_ready SHALL be 0, busy SHALL be 1 and out_valid SHALL equal the one-hot decode of sel. Latency from the accept edge to out_valid is one cycle.
REQ-018 In HOLD, out_ready[sel]=1 at an edge SHALL complete the transfer: ptr becomes sel+1 mod 4 and the FSM returns to IDLE. Throughput is therefore one word per two cycles at best.
REQ-019 In HOLD, out_ready[sel]=0 SHALL increment the wait counter.
REQ-020 When the wait counter reaches TIMEOUT, the stalled lane SHALL be skipped: sel becomes sel+1 mod 4, the wait counter clears, and the word stays held and is never dropped.
REQ-021 Lane index arithmetic SHALL wrap modulo 4: lane 3 is followed by lane 0.
REQ-022 out_ready bits for lanes other than sel SHALL be ignored.
REQ-023 out_data SHALL remain stable throughout HOLD and SHALL retain its last value in IDLE.

Reset
REQ-024 On reset assertion, at any time including mid-HOLD, the module SHALL enter IDLE with ptr=0, sel=0, wait counter=0, out_data=0, out_valid=0, busy=0, in_ready=1 and all counters=0; any held word is discarded.

Configuration
REQ-025 Macro DEMUX_SCHED_COUNT_EN defined: the module SHALL add output port dcount, width 4*CNT_W. Lane i's field is dcount[i*CNT_W +: CNT_W]. Each field increments by 1 on each completed transfer to that lane and saturates at all-ones.
REQ-026 Macro DEMUX_SCHED_COUNT_EN undefined: the dcount port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset, then in_valid=1, in_data=0x11, out_ready=4'b1111 -> out_valid=0001 one cycle later, then ptr=1. A second word 0x22 -> out_valid=0010 with out_data=0x22.
REQ-028 Four words 0xA0..0xA3, all lanes ready -> delivered to lanes 0,1,2,3 in order. The fifth word goes to lane 0 (wrap).
REQ-029 Word held on lane 2 with out_ready=4'b1011, TIMEOUT=4 -> out_valid=0100 for 4 cycles, then 1000. It transfers to lane 3 and ptr becomes 0.
REQ-030 All out_ready=0 for 20 cycles -> sel cycles 0,1,2,3,0 every 4 cycles, busy stays 1 and out_data is unchanged. Setting out_ready=4'b1111 -> transfer completes on the next edge.
REQ-031 Reset asserted asynchronously mid-HOLD with out_data=0x5A -> outputs reach their REQ-024 values before the next clock edge. The next accepted word goes to lane 0.
REQ-032 With DEMUX_SCHED_COUNT_EN and CNT_W=2, five transfers to lane 1 -> dcount lane-1 field reads 3 (saturated) and the other lanes read 0.
